// File: rtl/p2_ram_arbiter.sv
// p2_ram_arbiter: shares the 512x16 pattern RAM between display fetch (A) and loader (B); define P2_ARB_STATS_EN to add statistics outputs
module p2_ram_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 16,
  parameter int BE_W         = 2,
  parameter int MAX_A_STREAK = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [BE_W-1:0]   b_be,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
`ifdef P2_ARB_STATS_EN
  ,
  output logic [15:0]       b_wait_cycles,
  output logic [15:0]       a_grant_count
`endif
);
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;
  localparam logic [3:0] MAX_S = 4'(MAX_A_STREAK);
  state_t            state;
  logic [3:0]        streak;
  logic [DATA_W-1:0] a_hold;
  logic [DATA_W-1:0] b_hold;
  logic              b_turn;
  // B wins a contested cycle only once A has used up its streak allowance
  assign b_turn  = a_req & b_req & (streak == MAX_S);
  assign a_gnt   = reset_n & a_req & ~b_turn;
  assign b_gnt   = reset_n & b_req & (~a_req | b_turn);
  // RAM read data is only valid in the response cycle, so present it directly then and hold it afterwards
  assign a_rdata = a_rvalid ? ram_readdata : a_hold;
  assign b_rdata = b_rvalid ? ram_readdata : b_hold;
  // Grant FSM, streak counter, issue stage and response stage; state doubles as the issue-stage owner tag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      streak         <= '0;
      ram_address    <= '0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
      ram_byteenable <= '0;
      ram_clken      <= 1'b0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
      a_hold         <= '0;
      b_hold         <= '0;
    end else begin
      state     <= a_gnt ? SERVE_A : b_gnt ? SERVE_B : IDLE;
      streak    <= (a_gnt & b_req) ? streak + 4'd1 : 4'd0;
      ram_clken <= 1'b1;
      ram_write <= b_gnt & b_write;
      if (a_gnt | b_gnt) begin
        ram_address    <= a_gnt ? a_addr : b_addr;
        ram_byteenable <= a_gnt ? '1 : b_be;
      end
      if (b_gnt) ram_writedata <= b_wdata;
      a_rvalid <= state == SERVE_A;
      b_rvalid <= state == SERVE_B && !ram_write;
      if (a_rvalid) a_hold <= ram_readdata;
      if (b_rvalid) b_hold <= ram_readdata;
    end
  end
`ifdef P2_ARB_STATS_EN
  // Saturating B stall counter and wrapping A grant counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_wait_cycles <= '0;
      a_grant_count <= '0;
    end else begin
      if (b_req && !b_gnt && b_wait_cycles != 16'hFFFF) b_wait_cycles <= b_wait_cycles + 16'd1;
      if (a_gnt) a_grant_count <= a_grant_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_p2_ram_arbiter.sv
// tb_p2_ram_arbiter: directed and randomized checks of p2_ram_arbiter against a RAM model and a behavioural arbiter model
module tb_p2_ram_arbiter;
  localparam int MAX = 8;
  typedef struct {int due; bit b; logic [15:0] d;} resp_t;
  logic clk = 0, reset_n = 0;
  logic a_req = 0, b_req = 0, b_write = 0;
  logic [8:0] a_addr = 0, b_addr = 0;
  logic [15:0] b_wdata = 0;
  logic [1:0] b_be = 0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, ram_write, ram_clken;
  logic [15:0] a_rdata, b_rdata, ram_writedata, ram_readdata;
  logic [8:0] ram_address;
  logic [1:0] ram_byteenable;
  logic [15:0] mem [512];
  logic [8:0] raddr = 0;
  logic seeded = 0;
  int chk = 0, errs = 0;
`ifdef P2_ARB_STATS_EN
  logic [15:0] bw, ag;
`endif

  p2_ram_arbiter #(.MAX_A_STREAK(MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_write(ram_write), .ram_writedata(ram_writedata),
    .ram_byteenable(ram_byteenable), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
`ifdef P2_ARB_STATS_EN
    , .b_wait_cycles(bw), .a_grant_count(ag)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: registered address, unregistered output, byte-enabled writes
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 512; i++) mem[i] <= 16'($urandom);
      seeded <= 1'b1;
    end else if (ram_clken) begin
      if (ram_write && ram_byteenable[0]) mem[ram_address][7:0] <= ram_writedata[7:0];
      if (ram_write && ram_byteenable[1]) mem[ram_address][15:8] <= ram_writedata[15:8];
      raddr <= ram_address;
    end
  end
  assign ram_readdata = mem[raddr];

  task automatic b_access(input logic w, input logic [8:0] ad, input logic [15:0] d, input logic [1:0] be, output logic g);
    b_req = 1; b_write = w; b_addr = ad; b_wdata = d; b_be = be;
    @(negedge clk); g = b_gnt;
    @(posedge clk); #1; b_req = 0;
  endtask

  task automatic a_access(input logic [8:0] ad, output logic g);
    a_req = 1; a_addr = ad;
    @(negedge clk); g = a_gnt;
    @(posedge clk); #1; a_req = 0;
  endtask

  task automatic watch(output int a_at, output int b_at, output logic [15:0] ad, output logic [15:0] bd);
    a_at = -1; b_at = -1; ad = 0; bd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_rvalid && a_at < 0) begin a_at = k; ad = a_rdata; end
      if (b_rvalid && b_at < 0) begin b_at = k; bd = b_rdata; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_write, ram_clken} !== 6'b0) begin errs++; $display("FAIL reset_ctrl got=%b exp=000000", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_write, ram_clken}); end
    chk++; if ({a_rdata, b_rdata, ram_writedata} !== 48'h0) begin errs++; $display("FAIL reset_data got=%h/%h/%h exp=0", a_rdata, b_rdata, ram_writedata); end
    chk++; if ({ram_address, ram_byteenable} !== 11'h0) begin errs++; $display("FAIL reset_addr got=%h/%b exp=0", ram_address, ram_byteenable); end
    a_req = 1; b_req = 1; #1;
    chk++; if ({a_gnt, b_gnt} !== 2'b00) begin errs++; $display("FAIL reset_gnt got=%b exp=00", {a_gnt, b_gnt}); end
    a_req = 0; b_req = 0;
    @(posedge clk); #1; reset_n = 1;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk++; if ({ram_clken, ram_write} !== 2'b10) begin errs++; $display("FAIL idle_clken k=%0d got=%b exp=10", k, {ram_clken, ram_write}); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_b_write_read();
    logic g; int aa, ba; logic [15:0] ad, bd;
    b_access(1, 9'h005, 16'h1234, 2'b11, g);
    chk++; if (g !== 1'b1) begin errs++; $display("FAIL bw_gnt got=%b exp=1", g); end
    watch(aa, ba, ad, bd);
    chk++; if (ba != -1 || aa != -1) begin errs++; $display("FAIL bw_rvalid got a=%0d b=%0d exp=-1/-1", aa, ba); end
    b_access(0, 9'h005, 16'h0, 2'b00, g);
    chk++; if (g !== 1'b1) begin errs++; $display("FAIL br_gnt got=%b exp=1", g); end
    watch(aa, ba, ad, bd);
    chk++; if (ba != 1 || aa != -1) begin errs++; $display("FAIL br_lat got a=%0d b=%0d exp=-1/1", aa, ba); end
    chk++; if (bd !== 16'h1234) begin errs++; $display("FAIL br_data got=%h exp=1234", bd); end
  endtask

  task automatic test_byte_enable();
    logic g; int aa, ba; logic [15:0] ad, bd;
    b_access(1, 9'h010, 16'h1234, 2'b11, g);
    b_access(1, 9'h010, 16'hABCD, 2'b01, g);
    b_access(0, 9'h010, 16'h0, 2'b00, g);
    watch(aa, ba, ad, bd);
    chk++; if (ba != 1 || bd !== 16'h12CD) begin errs++; $display("FAIL be_read got at=%0d data=%h exp at=1 data=12cd", ba, bd); end
  endtask

  task automatic test_hazard();
    logic g; int aa, ba; logic [15:0] ad, bd;
    b_access(1, 9'h1FF, 16'h5A5A, 2'b11, g);
    a_access(9'h1FF, g);
    chk++; if (g !== 1'b1) begin errs++; $display("FAIL hz_gnt got=%b exp=1", g); end
    watch(aa, ba, ad, bd);
    chk++; if (aa != 1 || ba != -1 || ad !== 16'h5A5A) begin errs++; $display("FAIL hz_read got at=%0d b=%0d data=%h exp at=1 b=-1 data=5a5a", aa, ba, ad); end
  endtask

  task automatic test_starvation();
    logic [1:0] eo [15];
    logic [15:0] ed [15];
    a_req = 1; a_addr = 9'h100; b_req = 1; b_write = 0; b_addr = 9'h005;
    for (int k = 0; k < 15; k++) begin
      eo[k] = k >= 12 ? 2'd0 : k == MAX ? 2'd2 : 2'd1;
      ed[k] = eo[k] == 2'd2 ? mem[b_addr] : mem[a_addr];
      @(negedge clk);
      chk++; if ({a_gnt, b_gnt} !== {eo[k] == 2'd1, eo[k] == 2'd2}) begin errs++; $display("FAIL starve_gnt k=%0d got=%b exp=%b", k, {a_gnt, b_gnt}, {eo[k] == 2'd1, eo[k] == 2'd2}); end
      if (k >= 2) begin
        chk++;
        if ({a_rvalid, b_rvalid} !== {eo[k-2] == 2'd1, eo[k-2] == 2'd2} ||
            (eo[k-2] != 2'd0 && (eo[k-2] == 2'd1 ? a_rdata : b_rdata) !== ed[k-2])) begin
          errs++; $display("FAIL starve_resp k=%0d got rv=%b a=%h b=%h exp owner=%0d data=%h", k, {a_rvalid, b_rvalid}, a_rdata, b_rdata, eo[k-2], ed[k-2]);
        end
      end
      @(posedge clk); #1;
      if (eo[k] == 2'd1) a_addr++;
      if (eo[k] == 2'd2) b_req = 0;
      if (k == 11) a_req = 0;
    end
  endtask

  task automatic test_random();
    logic [15:0] sh [512];
    resp_t pend [$];
    int run = 0;
    logic ea, eb, ra, rb;
    for (int i = 0; i < 512; i++) sh[i] = mem[i];
    for (int c = 0; c < 320; c++) begin
      if (c < 300) begin
        if (!a_req && $urandom_range(0, 2) != 0) begin a_req = 1; a_addr = 9'($urandom_range(0, 15)); end
        if (!b_req && $urandom_range(0, 2) != 0) begin
          b_req = 1; b_write = 1'($urandom_range(0, 1)); b_addr = 9'($urandom_range(0, 15));
          b_wdata = 16'($urandom); b_be = 2'($urandom_range(0, 3));
        end
      end
      @(negedge clk);
      eb = b_req && !(a_req && run < MAX);
      ea = a_req && !eb;
      ra = pend.size() > 0 && pend[0].due == c && !pend[0].b;
      rb = pend.size() > 0 && pend[0].due == c && pend[0].b;
      chk++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== {ea, eb, ra, rb}) begin errs++; $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, {a_gnt, b_gnt, a_rvalid, b_rvalid}, {ea, eb, ra, rb}); end
      if (ra) begin chk++; if (a_rdata !== pend[0].d) begin errs++; $display("FAIL rnd_adata c=%0d got=%h exp=%h", c, a_rdata, pend[0].d); end end
      if (rb) begin chk++; if (b_rdata !== pend[0].d) begin errs++; $display("FAIL rnd_bdata c=%0d got=%h exp=%h", c, b_rdata, pend[0].d); end end
      if (ra || rb) void'(pend.pop_front());
      if (ea) begin
        pend.push_back('{c + 2, 1'b0, sh[a_addr]});
        run = b_req ? run + 1 : 0;
      end else if (eb) begin
        if (b_write) begin
          if (b_be[0]) sh[b_addr][7:0] = b_wdata[7:0];
          if (b_be[1]) sh[b_addr][15:8] = b_wdata[15:8];
        end else pend.push_back('{c + 2, 1'b1, sh[b_addr]});
        run = 0;
      end else run = 0;
      @(posedge clk); #1;
      if (ea) a_req = 0;
      if (eb) b_req = 0;
    end
  endtask

  task automatic test_mid_reset();
    logic g;
    b_access(0, 9'h005, 16'h0, 2'b00, g);
    reset_n = 0; #1;
    chk++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_write, ram_clken} !== 6'b0) begin errs++; $display("FAIL mrst_ctrl got=%b exp=000000", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_write, ram_clken}); end
    chk++; if ({a_rdata, b_rdata, ram_writedata, ram_address, ram_byteenable} !== 59'h0) begin errs++; $display("FAIL mrst_data got=%h/%h/%h/%h/%b exp=0", a_rdata, b_rdata, ram_writedata, ram_address, ram_byteenable); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk++; if (b_rvalid !== 1'b0) begin errs++; $display("FAIL mrst_rvalid k=%0d got=%b exp=0", k, b_rvalid); end
    end
    @(posedge clk); #1; reset_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_b_write_read();
    test_byte_enable();
    test_hazard();
    test_starvation();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end
endmodule

// File: doc/p2_ram_arbiter.md
Name: p2_ram_arbiter

Overview:
- Shares the 512x16 single-port pattern RAM (p2) between two requesters.
  - Port A: display fetch. Read-only, high priority.
  - Port B: loader/host. Read/write, low priority.
- At most one RAM access is issued per cycle.
- A streak counter guarantees Port B a slot after a bounded run of consecutive A grants.
- Read data is routed back to whichever requester issued the read. It returns one cycle after issue, which is the RAM's address-registered, unregistered-output latency.

Parameters:
- ADDR_W, 9, RAM word-address width (512 words).
- DATA_W, 16, RAM data width.
- BE_W, 2, byte-enable width (DATA_W/8).
- MAX_A_STREAK, 8, maximum consecutive A grants while B is waiting. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- a_req  in  1  A read request; held until a_gnt.
- a_addr  in  ADDR_W  A read address.
- a_gnt  out  1  A request accepted this cycle.
- a_rvalid  out  1  a_rdata valid; one-cycle pulse.
- a_rdata  out  DATA_W  A read data.
- b_req  in  1  B request; held until b_gnt.
- b_write  in  1  1 = write, 0 = read.
- b_addr  in  ADDR_W  B address.
- b_wdata  in  DATA_W  B write data.
- b_be  in  BE_W  B byte enables (writes only).
- b_gnt  out  1  B request accepted this cycle.
- b_rvalid  out  1  b_rdata valid; one-cycle pulse; never asserted for writes.
- b_rdata  out  DATA_W  B read data.
- ram_address  out  ADDR_W  to RAM address.
- ram_write  out  1  to RAM write enable.
- ram_writedata  out  DATA_W  to RAM data.
- ram_byteenable  out  BE_W  to RAM byte enables.
- ram_clken  out  1  to RAM clock enable; tied high except while in reset.
- ram_readdata  in  DATA_W  from RAM q.

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility):
  - All gnt/rvalid outputs 0; ram_write 0; ram_address 0; ram_writedata 0; ram_byteenable 0; ram_clken 0.
  - rdata outputs 0; streak counter 0; FSM = IDLE.
- Grant decision is combinational from the request inputs and registered state.
  - Only the a_gnt and b_gnt outputs are combinational.
  - RAM-side outputs are registered: the access is presented to the RAM the cycle after the grant.
- FSM states:
  - IDLE: no requests pending.
  - SERVE_A: last grant went to A.
  - SERVE_B: last grant went to B.
- Arbitration each cycle:
  - Only a_req: grant A.
  - Only b_req: grant B.
  - Both, with streak < MAX_A_STREAK: grant A and increment the streak.
  - Both, with streak == MAX_A_STREAK: grant B and clear the streak.
  - Streak clears on any B grant and on any cycle with b_req == 0.
  - Neither: IDLE. ram_write is 0 and the address holds its last value.
- Issue stage, the cycle after a grant:
  - ram_* carry the granted access.
  - A 1-bit owner tag and a read flag are registered alongside.
- Response stage: one cycle after issue, if the issued access was a read:
  - Capture ram_readdata into the owner's rdata register.
  - Pulse the owner's rvalid for one cycle.
  - Total latency from gnt to rvalid is 2 cycles.
- Throughput: one access per cycle with back-to-back grants allowed. Responses are in issue order, and no more than 2 accesses are in flight.
- B write immediately followed by an A read of the same address: A returns the new data, because the write commits before the read's address cycle.
- Simultaneous events: a new grant and a response in the same cycle are independent and both occur.
- Reset mid-operation: in-flight accesses are dropped, no rvalid is produced, and any pending write is not issued.
- Address is not checked; it wraps naturally in ADDR_W bits.

Optional Feature:
- Macro: P2_ARB_STATS_EN.
- Defined: adds two outputs, both cleared by reset.
  - b_wait_cycles: 16-bit, saturating. Counts cycles with b_req == 1 and b_gnt == 0.
  - a_grant_count: 16-bit, wrapping.
- Undefined: these outputs and their counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then idle:
  - All outputs at their reset values.
  - After reset release, ram_clken = 1 and ram_write = 0 indefinitely.
- B write, then B read:
  - Write 0x1234 to addr 0x005 with be = 2'b11.
  - Read addr 0x005: b_rvalid 2 cycles after b_gnt with b_rdata = 0x1234; a_rvalid never asserted.
- Byte-enable write:
  - Write 0xABCD to addr 0x010 with be = 2'b01 over existing 0x1234.
  - Read back returns 0x12CD.
- Starvation limit:
  - a_req held high with incrementing addresses; b_req high from cycle 0 (MAX_A_STREAK = 8).
  - Exactly 8 a_gnt, then 1 b_gnt, then A resumes.
  - Responses return in issue order, each to the correct owner.
- Write-then-read hazard:
  - B writes 0x5A5A to addr 0x1FF; A reads 0x1FF on the next grant.
  - a_rdata = 0x5A5A.
- Mid-operation reset:
  - Assert reset_n = 0 one cycle after a B read grant.
  - No b_rvalid is produced, and all outputs return to their reset values immediately.
